// File: rtl/adpll_pkg.sv
// Shared ADPLL constants and the loop-filter FSM state type.
// Imported by the filter interface and RTL; no ports.
package adpll_pkg;

    localparam int K_W         = 13;
    localparam int DCO_BASE    = 2500;
    localparam int K_LIM_DEF   = 2490;
    localparam int INT_LIM_DEF = K_LIM_DEF << 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PROD,
        ST_UPDATE,
        ST_OUTPUT
    } pi_state_e;

endpackage

// File: rtl/pi_loop_filter_if.sv
// Sample/tuning-word bundle between phase detector, loop filter and DCO.
// master: err, err_valid, freeze, int_clr out; err_ready, K_signed, k_valid, locked in.
interface pi_loop_filter_if #(
    parameter int ERR_W = 12
);

    logic signed [ERR_W-1:0]             err;
    logic                                err_valid;
    logic                                err_ready;
    logic                                freeze;
    logic                                int_clr;
    logic signed [adpll_pkg::K_W-1:0]    K_signed;
    logic                                k_valid;
    logic                                locked;

    modport master (
        output err, err_valid, freeze, int_clr,
        input  err_ready, K_signed, k_valid, locked
    );

    modport slave (
        input  err, err_valid, freeze, int_clr,
        output err_ready, K_signed, k_valid, locked
    );

endinterface

// File: rtl/sat_signed.sv
// Combinational symmetric signed clamp to +/-LIM, narrowing IN_W -> OUT_W.
// Ports: din (signed IN_W) in, dout (signed OUT_W) out.
module sat_signed #(
    parameter int IN_W  = 25,
    parameter int OUT_W = 13,
    parameter int LIM   = 2490
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    localparam logic signed [IN_W-1:0] HI = IN_W'(LIM);
    localparam logic signed [IN_W-1:0] LO = -HI;

    always_comb begin
        if (din > HI) begin
            dout = HI[OUT_W-1:0];
        end else if (din < LO) begin
            dout = LO[OUT_W-1:0];
        end else begin
            dout = din[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/pi_loop_filter.sv
// ADPLL PI loop filter: 4-cycle IDLE/PROD/UPDATE/OUTPUT pipeline, clamped integrator.
// Ports: clk, rst (sync, active-high), bus (slave). Lock detect: ADPLL_LOCK_DETECT_EN.
module pi_loop_filter
    import adpll_pkg::*;
#(
    parameter int ERR_W     = 12,
    parameter int KP        = 4,
    parameter int KI        = 1,
    parameter int FRAC_BITS = 4,
    parameter int ACC_W     = 24,
    parameter int K_LIM     = K_LIM_DEF,
    parameter int INT_LIM   = INT_LIM_DEF,
    parameter int LOCK_TOL  = 2,
    parameter int LOCK_CNT  = 16
) (
    input  logic           clk,
    input  logic           rst,
    pi_loop_filter_if.slave bus
);

    localparam int PW = ERR_W + 9;
    localparam int SW = ACC_W + 1;

    localparam logic signed [PW-1:0] KP_X = PW'(KP);
    localparam logic signed [PW-1:0] KI_X = PW'(KI);

    pi_state_e state_q, state_d;

    logic signed [ERR_W-1:0] err_q, err_d;
    logic signed [PW-1:0]    prop_q, prop_d;
    logic signed [PW-1:0]    inc_q, inc_d;
    logic signed [ACC_W-1:0] integ_q, integ_d;
    logic signed [ACC_W-1:0] integ_sat, integ_new;
    logic signed [SW-1:0]    integ_add, sum, sum_sh;
    logic signed [K_W-1:0]   k_q, k_d, k_sat;
    logic                    k_valid_q, k_valid_d;
    logic                    ready_q, ready_d;

    // Integrator add is one bit wider than the accumulator so it cannot wrap.
    always_comb begin
        integ_add = SW'(integ_q) + SW'(inc_q);
        if (bus.int_clr) begin
            integ_new = '0;
        end else if (bus.freeze) begin
            integ_new = integ_q;
        end else begin
            integ_new = integ_sat;
        end
        sum    = SW'(prop_q) + SW'(integ_new);
        sum_sh = sum >>> FRAC_BITS;
    end

    sat_signed #(
        .IN_W (SW),
        .OUT_W(ACC_W),
        .LIM  (INT_LIM)
    ) u_int_sat (
        .din (integ_add),
        .dout(integ_sat)
    );

    sat_signed #(
        .IN_W (SW),
        .OUT_W(K_W),
        .LIM  (K_LIM)
    ) u_out_sat (
        .din (sum_sh),
        .dout(k_sat)
    );

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        prop_d    = prop_q;
        inc_d     = inc_q;
        integ_d   = integ_q;
        k_d       = k_q;
        k_valid_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.err_valid) begin
                    err_d   = bus.err;
                    state_d = ST_PROD;
                end
            end
            ST_PROD: begin
                prop_d  = PW'(err_q) * KP_X;
                inc_d   = PW'(err_q) * KI_X;
                state_d = ST_UPDATE;
            end
            // Output word is registered on the way into OUTPUT so it is
            // visible (with k_valid) during the OUTPUT cycle.
            ST_UPDATE: begin
                integ_d   = integ_new;
                k_d       = k_sat;
                k_valid_d = 1'b1;
                state_d   = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            err_q     <= '0;
            prop_q    <= '0;
            inc_q     <= '0;
            integ_q   <= '0;
            k_q       <= '0;
            k_valid_q <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            prop_q    <= prop_d;
            inc_q     <= inc_d;
            integ_q   <= integ_d;
            k_q       <= k_d;
            k_valid_q <= k_valid_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.err_ready = ready_q;
    assign bus.K_signed  = k_q;
    assign bus.k_valid   = k_valid_q;

`ifdef ADPLL_LOCK_DETECT_EN
    localparam int LCW = $clog2(LOCK_CNT + 1);
    localparam logic signed [ERR_W-1:0] TOL_X = ERR_W'(LOCK_TOL);
    localparam logic [LCW-1:0] CNT_MAX = LCW'(LOCK_CNT);

    logic [LCW-1:0] lcnt_q, lcnt_d;
    logic           locked_q, locked_d;
    logic           in_win;

    // Updated alongside the output word so locked changes in the OUTPUT cycle.
    always_comb begin
        in_win   = (err_q >= -TOL_X) && (err_q <= TOL_X);
        lcnt_d   = lcnt_q;
        locked_d = locked_q;
        if (state_q == ST_UPDATE) begin
            if (bus.int_clr) begin
                lcnt_d   = '0;
                locked_d = 1'b0;
            end else if (in_win) begin
                if (lcnt_q != CNT_MAX) begin
                    lcnt_d = lcnt_q + LCW'(1);
                end
                locked_d = (lcnt_d == CNT_MAX);
            end else begin
                lcnt_d   = '0;
                locked_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lcnt_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            lcnt_q   <= lcnt_d;
            locked_q <= locked_d;
        end
    end

    assign bus.locked = locked_q;
`else
    assign bus.locked = 1'b0;
`endif

endmodule

// File: tb/tb_pi_loop_filter.sv
// Scoreboard bench for pi_loop_filter: directed + random samples vs an integer model.
// Build with +define+ADPLL_LOCK_DETECT_EN to also cover lock detection.
module tb_pi_loop_filter;
    import adpll_pkg::*;

    localparam int KP      = 4;
    localparam int KI      = 1;
    localparam int INT_LIM = 39840;
    localparam int K_LIM   = 2490;

    typedef struct {
        int k;
        int lk;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pi_loop_filter_if #(.ERR_W(12)) bus ();

    pi_loop_filter #(.ERR_W(12)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    exp_t exp_q[$];
    int phase   = 0;
    int m_err   = 0;
    int m_integ = 0;
    int k_hold  = 0;
    int lk_hold = 0;
    int lcnt    = 0;
    int acc_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int v, input int lim);
        if (v > lim) return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    // Reference model: one sample takes 4 cycles; freeze/int_clr are
    // sampled two edges after acceptance.
    task automatic model_update(input bit fr, input bit clr);
        int s;
        exp_t e;
        if (clr) begin
            m_integ = 0;
        end else if (!fr) begin
            m_integ = clamp(m_integ + m_err * KI, INT_LIM);
        end
        s = m_err * KP + m_integ;
        k_hold = clamp(s >>> 4, K_LIM);
`ifdef ADPLL_LOCK_DETECT_EN
        if (clr) begin
            lcnt = 0;
            lk_hold = 0;
        end else if (m_err >= -2 && m_err <= 2) begin
            if (lcnt < 16) lcnt++;
            lk_hold = (lcnt == 16) ? 1 : 0;
        end else begin
            lcnt = 0;
            lk_hold = 0;
        end
`endif
        e.k = k_hold;
        e.lk = lk_hold;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            phase = 0;
            m_integ = 0;
            k_hold = 0;
            lk_hold = 0;
            lcnt = 0;
            exp_q.delete();
        end else begin
            case (phase)
                0: if (bus.err_valid) begin
                    m_err = int'(bus.err);
                    phase = 1;
                    acc_cnt++;
                end
                1: phase = 2;
                2: begin
                    model_update(bus.freeze, bus.int_clr);
                    phase = 3;
                end
                default: phase = 0;
            endcase
        end
    end

    // Monitor: sampled 1 time unit after every active edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst) begin
            check("err_ready", int'(bus.err_ready), (phase == 0) ? 1 : 0);
            check("k_valid", int'(bus.k_valid), (exp_q.size() != 0) ? 1 : 0);
            if (bus.k_valid && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("K_signed", int'(bus.K_signed), e.k);
                check("locked_upd", int'(bus.locked), e.lk);
            end else begin
                exp_q.delete();
                check("K_hold", int'(bus.K_signed), k_hold);
                check("locked_hold", int'(bus.locked), lk_hold);
            end
        end
    end

    task automatic wait_accept(input int c0);
        for (int i = 0; i < 8 && acc_cnt == c0; i++) begin
            @(posedge clk);
            #1;
        end
        check("accept_timeout", (acc_cnt != c0) ? 1 : 0, 1);
    endtask

    task automatic send(input int e, input bit fr, input bit clr);
        int c0;
        @(negedge clk);
        bus.err = 12'(e);
        bus.err_valid = 1'b1;
        bus.freeze = fr;
        bus.int_clr = clr;
        c0 = acc_cnt;
        wait_accept(c0);
        @(negedge clk);
        bus.err_valid = 1'b0;
        repeat (2) @(negedge clk);
        bus.freeze = 1'b0;
        bus.int_clr = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_k(input string name, input int exp);
        check(name, int'(bus.K_signed), exp);
    endtask

    initial begin
        int c0;
        logic [11:0] r;
        rst = 1'b1;
        bus.err = '0;
        bus.err_valid = 1'b0;
        bus.freeze = 1'b0;
        bus.int_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_K", int'(bus.K_signed), 0);
        check("rst_ready", int'(bus.err_ready), 1);
        check("rst_kvalid", int'(bus.k_valid), 0);
        check("rst_locked", int'(bus.locked), 0);

        send(16, 0, 0);
        chk_k("err16_first", 5);
        send(16, 0, 0);
        chk_k("err16_second", 6);

        reset_dut();
        send(-1, 0, 0);
        chk_k("err_m1_floor", -1);
        reset_dut();
        send(2047, 0, 0);
        chk_k("err_2047", 639);

        reset_dut();
        for (int i = 0; i < 30; i++) send(2047, 0, 0);
        chk_k("sat_pos", 2490);
        reset_dut();
        for (int i = 0; i < 30; i++) send(-2048, 0, 0);
        chk_k("sat_neg", -2490);

        reset_dut();
        send(16, 0, 0);
        send(16, 0, 0);
        send(16, 1, 0);
        chk_k("freeze", 6);
        send(16, 0, 1);
        chk_k("int_clr", 4);

        // err_valid held high: samples offered while busy are dropped.
        @(negedge clk);
        bus.err_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r = 12'($urandom);
            bus.err = $signed(r);
            @(negedge clk);
        end
        bus.err_valid = 1'b0;
        repeat (4) @(negedge clk);

        reset_dut();
        send(16, 0, 0);
        @(negedge clk);
        bus.err = 12'(16);
        bus.err_valid = 1'b1;
        c0 = acc_cnt;
        wait_accept(c0);
        @(negedge clk);
        bus.err_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstupd_K", int'(bus.K_signed), 0);
        check("rstupd_ready", int'(bus.err_ready), 1);
        check("rstupd_kvalid", int'(bus.k_valid), 0);

        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 29) == 0) reset_dut();
            r = 12'($urandom);
            send(int'($signed(r)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0));
        end

`ifdef ADPLL_LOCK_DETECT_EN
        reset_dut();
        for (int i = 1; i <= 16; i++) begin
            send(1, 0, 0);
            check("lock_ramp", int'(bus.locked), (i == 16) ? 1 : 0);
        end
        send(5, 0, 0);
        check("lock_drop", int'(bus.locked), 0);
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pi_loop_filter.md
Name: pi_loop_filter

Overview:
- Digital proportional-integral loop filter for the ADPLL.
- Sits directly upstream of the threshold-based DCO. Consumes signed phase-error samples from the phase detector.
- Produces the saturated 13-bit signed tuning word K_signed that the DCO subtracts from its base threshold.
- Gains are shift/multiply based; the integrator is clamped for anti-windup; the output is held between updates.

Parameters:
- ERR_W, 12, phase-error input width (signed).
- KP, 4, proportional gain multiplier (unsigned, 0..255).
- KI, 1, integral gain multiplier (unsigned, 0..255).
- FRAC_BITS, 4, fractional bits removed before output (arithmetic right shift).
- ACC_W, 24, integrator width (signed).
- K_LIM, 2490, output magnitude limit; keeps DCO threshold within 10..4990 at base 2500.
- INT_LIM, 39840, integrator magnitude limit (K_LIM << FRAC_BITS).
- LOCK_TOL, 2, lock window on |err| (LOCK_DETECT_EN only).
- LOCK_CNT, 16, consecutive in-window samples to declare lock (LOCK_DETECT_EN only).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- err  in  ERR_W  signed phase error sample.
- err_valid  in  1  err qualifier.
- err_ready  out  1  high when the filter can accept a sample.
- freeze  in  1  hold integrator (P path still active).
- int_clr  in  1  synchronous integrator clear.
- K_signed  out  13  signed tuning word to the DCO.
- k_valid  out  1  one-cycle pulse when K_signed updates.
- locked  out  1  lock indicator (LOCK_DETECT_EN only; tied 0 otherwise).

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - On rst: state=IDLE, integrator=0, K_signed=0, k_valid=0, err_ready=1, locked=0, lock counter=0.
  - rst mid-operation aborts the sample in flight; no k_valid is issued.
- FSM states: IDLE, PROD, UPDATE, OUTPUT.
  - IDLE: err_ready=1. When err_valid=1, register err and go to PROD. Otherwise stay.
  - PROD: prop = err*KP (ERR_W+9 bits signed); inc = err*KI. Go to UPDATE.
  - UPDATE: compute the integrator and sum (see below). Go to OUTPUT.
    - int_clr=1: integrator=0 (priority over freeze and update).
    - else freeze=1: integrator held.
    - else integrator = clamp(integ + inc, -INT_LIM, +INT_LIM), with the add carried at ACC_W+1 bits (no wrap).
    - sum = prop + new integrator (ACC_W+1 bits).
  - OUTPUT: K_signed = clamp(sum >>> FRAC_BITS, -K_LIM, +K_LIM) (arithmetic shift, floor toward -inf). k_valid=1 this cycle only. Go to IDLE.
- Handshake and throughput:
  - err_ready=0 in PROD/UPDATE/OUTPUT. err_valid asserted then is ignored (dropped, no side effect).
  - Latency: accept at cycle N, K_signed and k_valid visible at cycle N+3. Next accept possible at N+4.
- Output hold: K_signed holds its value between updates.
- int_clr/freeze are only sampled in UPDATE. int_clr asserted outside UPDATE has no effect.

Optional Feature:
- Macro: ADPLL_LOCK_DETECT_EN.
- Defined:
  - In OUTPUT, if |err| <= LOCK_TOL, increment lock counter (saturating at LOCK_CNT); else counter=0 and locked=0.
  - locked=1 when counter reaches LOCK_CNT.
  - int_clr also clears counter and locked.
- Undefined: no counter logic; locked tied to 0.

Decomposition:
- Shared package adpll_pkg:
  - Constants: K_W=13, DCO base threshold 2500, default K_LIM, INT_LIM.
  - State enum typedef for the filter FSM.
- One natural sub-module: sat_signed (parameterised in/out width and limit, combinational clamp). Instantiated twice: integrator clamp and output clamp.

Test Plan:
- Reset, then err=16 valid (KP=4, KI=1, FRAC_BITS=4) -> k_valid 3 cycles after accept, K_signed=5 (64+16=80>>>4). Second err=16 -> K_signed=6 (64+32=96).
- From reset err=-1 -> K_signed=-1 (sum -5, floor). err=2047 from reset -> K_signed=639 (8188+2047=10235>>>4).
- err=2047 repeated 30 samples -> integrator saturates at 39840, never wraps; K_signed clamps to 2490. Mirror with err=-2048 -> K_signed=-2490.
- Handshake and freeze:
  - err_valid held high continuously -> exactly one accept per 4 cycles; err_ready low in PROD/UPDATE/OUTPUT.
  - freeze=1 during UPDATE with err=16 and integ=32 -> integ stays 32, K_signed=6.
- int_clr and reset:
  - int_clr=1 in UPDATE with integ=32, err=16 -> integ=0, K_signed=4.
  - rst asserted in UPDATE -> no k_valid, K_signed=0, err_ready=1 next cycle.
- With ADPLL_LOCK_DETECT_EN: 16 samples err=1 -> locked=1 on the 16th k_valid. Then err=5 -> locked=0 in the same OUTPUT cycle.
